// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_WAIT  = 2'd2
    } hz_state_e;

    localparam int REG_X0 = 0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller beside ID: load-use stalls, MDU occupancy of EX and EX redirects,
// with saturating stall/flush performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int MDU_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mdu_start,
    input  logic              mdu_done,
    input  logic              ex_redirect,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    hz_state_e  state, state_next;
    logic [1:0] wait_cnt, wait_cnt_next;
    logic       mdu_pending, mdu_pending_next;
    logic       hit;
    logic       mdu_start_ok;

    assign hit = ex_mem_read && (ex_rd != REG_AW'(REG_X0)) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));

    assign mdu_start_ok = ex_mdu_start && (MDU_EN != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mdu_pending <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mdu_pending <= mdu_pending_next;
        end
    end

    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        mdu_pending_next = mdu_pending;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;
        ex_hold          = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_redirect) begin
                        if_id_flush      = 1'b1;
                        id_ex_bubble     = 1'b1;
                        mdu_pending_next = 1'b0;
                    end else if (hit) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        // An MDU op already in EX advances past the bubble; enter MDU_WAIT once the stall drains.
                        if (LOAD_STALL > 1) begin
                            state_next       = LOAD_WAIT;
                            wait_cnt_next    = 2'(LOAD_STALL - 1);
                            mdu_pending_next = mdu_start_ok;
                        end else if (mdu_start_ok) begin
                            state_next = MDU_WAIT;
                        end
                    end else if (mdu_start_ok) begin
                        state_next = MDU_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (ex_redirect) begin
                        if_id_flush      = 1'b1;
                        id_ex_bubble     = 1'b1;
                        state_next       = IDLE;
                        wait_cnt_next    = '0;
                        mdu_pending_next = 1'b0;
                    end else begin
                        pc_write         = 1'b0;
                        if_id_write      = 1'b0;
                        id_ex_bubble     = 1'b1;
                        mdu_pending_next = mdu_pending || mdu_start_ok;
                        if (wait_cnt == 2'd1) begin
                            state_next       = (mdu_pending || mdu_start_ok) ? MDU_WAIT : IDLE;
                            wait_cnt_next    = '0;
                            mdu_pending_next = 1'b0;
                        end else begin
                            wait_cnt_next = wait_cnt - 2'd1;
                        end
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_next = IDLE;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_hold     = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three configurations share one stimulus stream and are checked
// against a cycle-level model, plus a vector table and directed corner-case sequences.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       ex_mem_read = 1'b0, ex_mdu_start = 1'b0, mdu_done = 1'b0, ex_redirect = 1'b0;

    logic        a_pc, a_ifw, a_fl, a_bub, a_hold;
    logic        b_pc, b_ifw, b_fl, b_bub, b_hold;
    logic        c_pc, c_ifw, c_fl, c_bub, c_hold;
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
    logic [2:0]  c_scnt, c_fcnt;

    logic [4:0]  outs [3];
    logic [15:0] scnt [3];
    logic [15:0] fcnt [3];

    assign outs[0] = {a_pc, a_ifw, a_fl, a_bub, a_hold};
    assign outs[1] = {b_pc, b_ifw, b_fl, b_bub, b_hold};
    assign outs[2] = {c_pc, c_ifw, c_fl, c_bub, c_hold};
    assign scnt[0] = a_scnt;
    assign scnt[1] = b_scnt;
    assign scnt[2] = {13'd0, c_scnt};
    assign fcnt[0] = a_fcnt;
    assign fcnt[1] = b_fcnt;
    assign fcnt[2] = {13'd0, c_fcnt};

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .LOAD_STALL(1), .MDU_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ex_redirect(ex_redirect), .pc_write(a_pc), .if_id_write(a_ifw),
        .if_id_flush(a_fl), .id_ex_bubble(a_bub), .ex_hold(a_hold),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    hazard_unit #(.REG_AW(5), .LOAD_STALL(3), .MDU_EN(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ex_redirect(ex_redirect), .pc_write(b_pc), .if_id_write(b_ifw),
        .if_id_flush(b_fl), .id_ex_bubble(b_bub), .ex_hold(b_hold),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    hazard_unit #(.REG_AW(5), .LOAD_STALL(1), .MDU_EN(1), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ex_redirect(ex_redirect), .pc_write(c_pc), .if_id_write(c_ifw),
        .if_id_flush(c_fl), .id_ex_bubble(c_bub), .ex_hold(c_hold),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

    int n_vec = 0;
    int n_err = 0;

    // Model: remaining load-stall cycles, MDU busy flag, deferred MDU entry, and event tallies.
    int ls   [3] = '{1, 3, 1};
    int cmax [3] = '{65535, 65535, 7};
    int rem  [3];
    bit busy [3];
    bit pend [3];
    int m_stall [3];
    int m_flush [3];

    // Output bundle order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold}
    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_REDIR = 5'b11110;
    localparam logic [4:0] O_MDU   = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic [4:0] e;
        bit h;
        @(negedge clk);
        h = ex_mem_read && (ex_rd != 5'd0) &&
            ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                e = O_RST;
                rem[i] = 0; busy[i] = 0; pend[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else if (busy[i]) begin
                e = mdu_done ? O_IDLE : O_MDU;
                if (mdu_done) busy[i] = 0;
            end else if (ex_redirect) begin
                e = O_REDIR;
                rem[i] = 0; pend[i] = 0;
            end else if (rem[i] > 0) begin
                e = O_STALL;
                pend[i] = pend[i] | ex_mdu_start;
                rem[i]--;
                if (rem[i] == 0) begin busy[i] = pend[i]; pend[i] = 0; end
            end else if (h) begin
                e = O_STALL;
                rem[i] = ls[i] - 1;
                if (rem[i] == 0) busy[i] = ex_mdu_start;
                else pend[i] = ex_mdu_start;
            end else begin
                e = O_IDLE;
                busy[i] = ex_mdu_start;
            end
            check($sformatf("model_outs[%0d]", i), 32'(outs[i]), 32'(e));
            check($sformatf("model_stall_cnt[%0d]", i), 32'(scnt[i]), 32'(m_stall[i]));
            check($sformatf("model_flush_cnt[%0d]", i), 32'(fcnt[i]), 32'(m_flush[i]));
            if (!rst) begin
                if (!e[4] && m_stall[i] < cmax[i]) m_stall[i]++;
                if (e[2] && m_flush[i] < cmax[i]) m_flush[i]++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_mem_read = 0; ex_mdu_start = 0; mdu_done = 0; ex_redirect = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_hit();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, redir;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{"hit_rs1",      5'd5, 5'd0, 5'd5, 1, 0, 1, 0, O_STALL};
        tbl[1] = '{"x0_rs1",       5'd0, 5'd0, 5'd0, 1, 0, 1, 0, O_IDLE};
        tbl[2] = '{"unused_rs2",   5'd3, 5'd7, 5'd7, 1, 0, 1, 0, O_IDLE};
        tbl[3] = '{"hit_rs2",      5'd3, 5'd7, 5'd7, 1, 1, 1, 0, O_STALL};
        tbl[4] = '{"not_load",     5'd5, 5'd0, 5'd5, 1, 0, 0, 0, O_IDLE};
        tbl[5] = '{"redir_hit",    5'd5, 5'd0, 5'd5, 1, 0, 1, 1, O_REDIR};
        tbl[6] = '{"redir_only",   5'd1, 5'd2, 5'd3, 1, 1, 0, 1, O_REDIR};
        tbl[7] = '{"rd_mismatch",  5'd4, 5'd6, 5'd5, 1, 1, 1, 0, O_IDLE};
        tbl[8] = '{"unused_rs1",   5'd9, 5'd0, 5'd9, 0, 0, 1, 0, O_IDLE};
        tbl[9] = '{"x0_rs2",       5'd1, 5'd0, 5'd0, 0, 1, 1, 0, O_IDLE};

        // Reset state
        #2;
        sample();
        check("reset_outs", 32'(outs[0]), 32'(O_RST));
        adv();
        rst = 0;

        // Table vectors on the LOAD_STALL=1 instance, which is back in IDLE after each
        foreach (tbl[k]) begin
            id_rs1 = tbl[k].rs1; id_rs2 = tbl[k].rs2; ex_rd = tbl[k].rd;
            id_rs1_used = tbl[k].u1; id_rs2_used = tbl[k].u2;
            ex_mem_read = tbl[k].mr; ex_redirect = tbl[k].redir;
            sample();
            check(tbl[k].name, 32'(outs[0]), 32'(tbl[k].exp));
            adv();
        end
        clear_inputs();
        tick();

        // Single-bubble load-use
        do_reset();
        set_hit();
        sample();
        check("ls1_stall", 32'(outs[0]), 32'(O_STALL));
        adv();
        clear_inputs();
        sample();
        check("ls1_stall_cnt", 32'(scnt[0]), 32'd1);
        adv();

        // Three-bubble load-use
        do_reset();
        set_hit();
        for (int s = 0; s < 3; s++) begin
            sample();
            check($sformatf("ls3_stall_c%0d", s), 32'(outs[1]), 32'(O_STALL));
            adv();
            clear_inputs();
        end
        sample();
        check("ls3_release", 32'(outs[1]), 32'(O_IDLE));
        adv();

        // Redirect during the second stall cycle
        do_reset();
        set_hit();
        tick();
        clear_inputs();
        ex_redirect = 1;
        sample();
        check("ls3_redir_outs", 32'(outs[1]), 32'(O_REDIR));
        adv();
        ex_redirect = 0;
        sample();
        check("ls3_redir_stall_cnt", 32'(scnt[1]), 32'd1);
        check("ls3_redir_flush_cnt", 32'(fcnt[1]), 32'd1);
        check("ls3_redir_after", 32'(outs[1]), 32'(O_IDLE));
        adv();

        // MDU occupancy: six held cycles, released on the done cycle
        do_reset();
        ex_mdu_start = 1;
        sample();
        check("mdu_start_cycle", 32'(outs[0]), 32'(O_IDLE));
        adv();
        ex_mdu_start = 0;
        for (int s = 0; s < 6; s++) begin
            sample();
            check($sformatf("mdu_hold_c%0d", s), 32'(outs[0]), 32'(O_MDU));
            adv();
        end
        mdu_done = 1;
        sample();
        check("mdu_done_release", 32'(outs[0]), 32'(O_IDLE));
        adv();
        mdu_done = 0;
        sample();
        check("mdu_stall_cnt", 32'(scnt[0]), 32'd6);
        adv();

        // Redirect together with a load hit
        do_reset();
        set_hit();
        ex_redirect = 1;
        sample();
        check("redir_hit_outs", 32'(outs[0]), 32'(O_REDIR));
        adv();
        clear_inputs();
        sample();
        check("redir_hit_flush_cnt", 32'(fcnt[0]), 32'd1);
        check("redir_hit_stall_cnt", 32'(scnt[0]), 32'd0);
        adv();

        // Counter saturation, then reset in the middle of MDU_WAIT
        do_reset();
        ex_mdu_start = 1;
        tick();
        ex_mdu_start = 0;
        for (int s = 0; s < 10; s++) tick();
        sample();
        check("sat_stall_cnt_w3", 32'(scnt[2]), 32'd7);
        check("nosat_stall_cnt_w16", 32'(scnt[0]), 32'd10);
        adv();
        #2;
        rst = 1;
        sample();
        check("mid_mdu_rst_cnt", 32'(scnt[2]), 32'd0);
        check("mid_mdu_rst_outs", 32'(outs[2]), 32'(O_RST));
        adv();
        rst = 0;
        sample();
        check("post_rst_idle", 32'(outs[2]), 32'(O_IDLE));
        adv();

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit any_busy;
            any_busy = busy[0] | busy[1] | busy[2];
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_mdu_start = ($urandom_range(0, 9) == 0);
            mdu_done     = ($urandom_range(0, 3) == 0);
            ex_redirect  = ($urandom_range(0, 7) == 0) && !any_busy && !ex_mdu_start;
            rst          = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
